reg_sampler: RTL

REG_SAMPLER -- requirements
Module: reg_sampler

---
 rtl/reg_sampler.sv | 89 ++++++++
 1 files changed

// File: rtl/reg_sampler.sv
// reg_sampler: dumps all 32 registers MSB-first as a byte stream over a valid/ready link; REG_SAMPLER_CHECKSUM_EN appends an XOR checksum byte
module reg_sampler (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        rse,
  output logic [4:0]  rsaddr,
  input  logic [31:0] rsdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
`ifdef REG_SAMPLER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, CHK, DONE} state_t;
  logic [7:0] r_csum;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif
  state_t      r_state;
  logic [4:0]  r_idx;
  logic [1:0]  r_cnt;
  logic [31:0] r_sr;
  logic        w_xfer;
  assign w_xfer   = tx_valid && tx_ready;
  assign rse      = r_state == READ;
  assign rsaddr   = r_idx;
  assign busy     = r_state != IDLE;
  assign done     = r_state == DONE;
`ifdef REG_SAMPLER_CHECKSUM_EN
  assign tx_valid = r_state == SEND || r_state == CHK;
  assign tx_data  = r_state == SEND ? r_sr[31:24] : r_state == CHK ? r_csum : 8'h00;
`else
  assign tx_valid = r_state == SEND;
  assign tx_data  = r_state == SEND ? r_sr[31:24] : 8'h00;
`endif
  // Dump sequencer: read a register, shift its four bytes out on each handshake, step to the next register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 5'd0;
      r_cnt   <= 2'd0;
      r_sr    <= 32'd0;
`ifdef REG_SAMPLER_CHECKSUM_EN
      r_csum  <= 8'h00;
`endif
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_idx   <= 5'd0;
          r_state <= READ;
`ifdef REG_SAMPLER_CHECKSUM_EN
          r_csum  <= 8'h00;
`endif
        end
        READ: begin
          r_sr    <= rsdata;
          r_cnt   <= 2'd0;
          r_state <= SEND;
        end
        SEND: if (w_xfer) begin
          r_sr  <= {r_sr[23:0], 8'h00};
          r_cnt <= r_cnt + 2'd1;
`ifdef REG_SAMPLER_CHECKSUM_EN
          r_csum <= r_csum ^ r_sr[31:24];
`endif
          if (r_cnt == 2'd3) begin
            if (r_idx == 5'd31) begin
`ifdef REG_SAMPLER_CHECKSUM_EN
              r_state <= CHK;
`else
              r_state <= DONE;
`endif
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_state <= READ;
            end
          end
        end
`ifdef REG_SAMPLER_CHECKSUM_EN
        CHK: if (w_xfer) r_state <= DONE;
`endif
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
